// File: rtl/button_click_decoder_pkg.sv
// Shared types and helpers for the button click decoder.
package button_pkg;

  // Event type field carried in the upper two bits of every queued event.
  typedef enum logic [1:0] {
    CLICK_NONE   = 2'd0,
    CLICK_SINGLE = 2'd1,
    CLICK_DOUBLE = 2'd2
  } click_type_e;

  // Per-button click state machine states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } click_state_e;

  // Event word width: two type bits plus enough bits to name any button.
  function automatic int evWidth(input int width);
    return 2 + $clog2(width);
  endfunction

endpackage

// File: rtl/button_click_decoder_if.sv
// Valid/ready event stream between the decoder and its consumer.
interface button_click_decoder_if
  import button_pkg::*;
#(
  parameter int WIDTH = 4
);

  localparam int EW = evWidth(WIDTH);

  logic          ev_valid;
  logic          ev_ready;
  logic [EW-1:0] ev_data;

  modport master (output ev_valid, output ev_data, input ev_ready);
  modport slave  (input ev_valid, input ev_data, output ev_ready);

endinterface

// File: rtl/button_click_decoder_click_fsm.sv
// One button's click classifier: window counter, click FSM and a
// one-entry pending register that holds the classified event until the
// arbiter grants it a FIFO slot.
module click_fsm
  import button_pkg::*;
#(
  parameter int WINDOW_CNT_MAX = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        press,
  input  logic        grant,
  output logic        pend_valid,
  output click_type_e pend_type,
  output logic        drop
);

  localparam int            CW       = $clog2(WINDOW_CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW_CNT_MAX - 1);

  click_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pendValid;
  click_type_e   r_pendType;

  logic          w_emit;
  click_type_e   w_emitType;

  // Classify: a press inside the window wins over a simultaneous timeout.
  always_comb begin
    w_emit     = 1'b0;
    w_emitType = CLICK_NONE;
    if (r_state == ST_WAIT) begin
      if (press) begin
        w_emit     = 1'b1;
        w_emitType = CLICK_DOUBLE;
      end else if (r_cnt == CNT_LAST) begin
        w_emit     = 1'b1;
        w_emitType = CLICK_SINGLE;
      end
    end
  end

  // Click FSM and window counter; transitions happen even if the event drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (press) begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_WAIT: begin
          if (w_emit) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Pending register: a grant frees the slot in the same cycle it refills.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pendValid <= 1'b0;
      r_pendType  <= CLICK_NONE;
    end else if (w_emit && (!r_pendValid || grant)) begin
      r_pendValid <= 1'b1;
      r_pendType  <= w_emitType;
    end else if (grant) begin
      r_pendValid <= 1'b0;
    end
  end

  assign drop       = w_emit && r_pendValid && !grant;
  assign pend_valid = r_pendValid;
  assign pend_type  = r_pendType;

endmodule

// File: rtl/button_click_decoder.sv
// Button click decoder top: per-button click FSMs feed a fixed-priority
// arbiter that loads an event FIFO read by software over a valid/ready
// stream; any lost event raises a sticky overflow flag.
module button_click_decoder
  import button_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int WINDOW_CNT_MAX = 25_000_000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            press,
  button_click_decoder_if.master      ev,
  output logic [$clog2(FIFO_DEPTH):0] ev_count,
  output logic                        overflow,
  input  logic                        clr_overflow
);

  localparam int IDW = $clog2(WIDTH);
  localparam int EW  = evWidth(WIDTH);
  localparam int AW  = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] w_pendValid;
  click_type_e      w_pendType [WIDTH];
  logic [WIDTH-1:0] w_drop;
  logic [WIDTH-1:0] w_grant;
  logic             w_found;
  logic [EW-1:0]    w_pushData;
  logic             w_push;
  logic             w_pop;
  logic             w_full;

  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             r_overflow;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : gen_btn
      click_fsm #(
        .WINDOW_CNT_MAX (WINDOW_CNT_MAX)
      ) u_click_fsm (
        .clk        (clk),
        .rst        (rst),
        .press      (press[g]),
        .grant      (w_grant[g]),
        .pend_valid (w_pendValid[g]),
        .pend_type  (w_pendType[g]),
        .drop       (w_drop[g])
      );
    end
  endgenerate

  // Fixed priority: lowest-index pending event gets the single FIFO slot.
  always_comb begin
    w_grant    = '0;
    w_found    = 1'b0;
    w_pushData = '0;
    if (!w_full) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_pendValid[i] && !w_found) begin
          w_found    = 1'b1;
          w_grant[i] = 1'b1;
          w_pushData = {w_pendType[i], IDW'(i)};
        end
      end
    end
  end

  assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_push = w_found;
  assign w_pop  = ev.ev_valid && ev.ev_ready;

  // FIFO storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= w_pushData;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (|w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign ev.ev_valid = (r_count != '0);
  assign ev.ev_data  = ev.ev_valid ? r_mem[r_rdPtr] : '0;
  assign ev_count    = r_count;
  assign overflow    = r_overflow;

endmodule
